// File: rtl/half_to_int.sv
// Iterative IEEE754 half-precision to signed integer converter with R_I/R_O pulse handshake.
// Define HALF_TO_INT_ROUND_EN for round-to-nearest-even; default build truncates toward zero.
module half_to_int #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       dataIn,
    input  logic              R_I,
    output logic [DATA_W-1:0] dataOut,
    output logic              R_O,
    output logic              REG_ERROR,
    output logic              busy
);
    localparam int unsigned MW = DATA_W + 11;
    localparam logic [MW-1:0] POS_LIM = {{(MW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM = {{(MW-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] INT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_SIGN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [MW-1:0]      r_mant;
    logic [4:0]         r_exp;
    logic               r_sign;
    logic               r_left;
    logic               r_err;
    logic               r_nan;
    logic [4:0]         r_cnt;
    logic [DATA_W-1:0]  r_dataOut;

    logic               w_special;
    logic               w_small;
    logic               w_left;
    logic [4:0]         w_shamt;
    logic [MW-1:0]      w_mag;
    logic               w_ovf;
    logic [DATA_W-1:0]  w_result;

    assign w_special = (r_exp == 5'd31);
    assign w_small   = (r_exp < 5'd15);
    assign w_left    = (r_exp > 5'd25);
    // Hidden-bit mantissa is worth 2^10, so the binary point sits at e = 25.
    assign w_shamt   = w_left ? (r_exp - 5'd25) : (5'd25 - r_exp);

`ifdef HALF_TO_INT_ROUND_EN
    logic r_guard;
    logic r_sticky;
    logic w_inc;

    assign w_inc = r_guard & (r_sticky | r_mant[0]);
    assign w_mag = r_mant + {{(MW-1){1'b0}}, w_inc};
`else
    assign w_mag = r_mant;
`endif

    always_comb begin
        w_ovf = r_sign ? (w_mag > NEG_LIM) : (w_mag > POS_LIM);
        if (r_err && r_nan) begin
            w_result = '0;
        end else if (r_err || w_ovf) begin
            w_result = r_sign ? INT_MIN : INT_MAX;
        end else if (r_sign) begin
            w_result = -w_mag[DATA_W-1:0];
        end else begin
            w_result = w_mag[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (R_I) w_next = S_UNPACK;
            end
            S_UNPACK: begin
                if (w_special || w_small || (w_shamt == 5'd0)) w_next = S_SIGN;
                else                                          w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == 5'd1) w_next = S_SIGN;
            end
            S_SIGN:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mant    <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_left    <= 1'b0;
            r_err     <= 1'b0;
            r_nan     <= 1'b0;
            r_cnt     <= '0;
            r_dataOut <= '0;
`ifdef HALF_TO_INT_ROUND_EN
            r_guard   <= 1'b0;
            r_sticky  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (R_I) begin
                        r_sign <= dataIn[15];
                        r_exp  <= dataIn[14:10];
                        r_mant <= {{(MW-11){1'b0}}, 1'b1, dataIn[9:0]};
                        r_err  <= 1'b0;
                        r_nan  <= 1'b0;
`ifdef HALF_TO_INT_ROUND_EN
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
`endif
                    end
                end
                S_UNPACK: begin
                    r_cnt  <= w_shamt;
                    r_left <= w_left;
                    if (w_special) begin
                        r_err  <= 1'b1;
                        r_nan  <= |r_mant[9:0];
                        r_mant <= '0;
                    end else if (w_small) begin
                        r_mant <= '0;
`ifdef HALF_TO_INT_ROUND_EN
                        // Only [0.5,1) can round up: the hidden bit becomes the guard.
                        r_guard  <= (r_exp == 5'd14);
                        r_sticky <= |r_mant[9:0];
`endif
                    end
                end
                S_SHIFT: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (r_left) begin
                        r_mant <= r_mant << 1;
                    end else begin
                        r_mant <= r_mant >> 1;
`ifdef HALF_TO_INT_ROUND_EN
                        r_guard  <= r_mant[0];
                        r_sticky <= r_sticky | r_guard;
`endif
                    end
                end
                S_SIGN: begin
                    r_dataOut <= w_result;
                    r_err     <= r_err | w_ovf;
                end
                default: begin
                end
            endcase
        end
    end

    assign dataOut   = r_dataOut;
    assign R_O       = (r_state == S_DONE);
    assign REG_ERROR = (r_state == S_DONE) && r_err;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_half_to_int.sv
// Randomized self-checking bench for half_to_int, comparing DATA_W=16 and DATA_W=32 instances
// against an arithmetic reference model of the half-precision value.
`timescale 1ns/1ps
module tb_half_to_int;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] dataIn;
    logic        R_I;
    logic [15:0] dataOut16;
    logic        R_O16, err16, busy16;
    logic [31:0] dataOut32;
    logic        R_O32, err32, busy32;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    half_to_int #(.DATA_W(16)) dut16 (
        .clk(clk), .reset(reset), .dataIn(dataIn), .R_I(R_I),
        .dataOut(dataOut16), .R_O(R_O16), .REG_ERROR(err16), .busy(busy16)
    );

    half_to_int #(.DATA_W(32)) dut32 (
        .clk(clk), .reset(reset), .dataIn(dataIn), .R_I(R_I),
        .dataOut(dataOut32), .R_O(R_O32), .REG_ERROR(err32), .busy(busy32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Value = (1024 + frac) * 2^(e-25) for normal numbers; subnormals are below 0.5.
    function automatic void ref_model(input logic [15:0] h, input int w,
                                      output longint val, output bit err, output int lat);
        int     e, f, sh;
        longint m, mag, maxp, minn;
`ifdef HALF_TO_INT_ROUND_EN
        longint rem, half;
`endif
        e    = int'(h[14:10]);
        f    = int'(h[9:0]);
        maxp = (longint'(1) << (w - 1)) - 1;
        minn = -maxp - 1;
        err  = 1'b0;
        lat  = 3;
        mag  = 0;
        if (e == 31) begin
            err = 1'b1;
            val = (f != 0) ? 0 : (h[15] ? minn : maxp);
            return;
        end
        if (e != 0) begin
            m = 1024 + f;
            if (e >= 25) begin
                mag = m << (e - 25);
            end else begin
                sh  = 25 - e;
                mag = m >> sh;
`ifdef HALF_TO_INT_ROUND_EN
                rem  = m - (mag << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && mag[0])) mag++;
`endif
            end
            if (e >= 15) lat = 3 + ((e > 25) ? (e - 25) : (25 - e));
        end
        val = h[15] ? -mag : mag;
        if (val > maxp) begin err = 1'b1; val = maxp; end
        if (val < minn) begin err = 1'b1; val = minn; end
    endfunction

    task automatic convert(input logic [15:0] h);
        longint v16, v32;
        bit     e16, e32;
        int     lat, lat32, n, nb;
        ref_model(h, 16, v16, e16, lat);
        ref_model(h, 32, v32, e32, lat32);
        @(negedge clk);
        dataIn = h;
        R_I    = 1'b1;
        @(negedge clk);
        R_I    = 1'b0;
        dataIn = 16'($urandom);
        n  = 1;
        nb = 0;
        while (1) begin
            if (busy16) nb++;
            if (R_O16 || n > 40) break;
            @(negedge clk);
            n++;
        end
        check($sformatf("latency %h", h), n, lat);
        check($sformatf("busy_cycles %h", h), nb, lat);
        check($sformatf("data16 %h", h), {16'b0, dataOut16}, {16'b0, v16[15:0]});
        check($sformatf("err16 %h", h), {31'b0, err16}, {31'b0, e16});
        check($sformatf("ro32 %h", h), {31'b0, R_O32}, 32'd1);
        check($sformatf("data32 %h", h), dataOut32, v32[31:0]);
        check($sformatf("err32 %h", h), {31'b0, err32}, {31'b0, e32});
        @(negedge clk);
        check($sformatf("ro_pulse %h", h), {31'b0, R_O16}, 32'd0);
        check($sformatf("idle %h", h), {31'b0, busy16}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] directed [15];
        logic [15:0] h;
        longint      v16, v32;
        bit          e16, e32;
        int          lat, nro;

        directed = '{16'h5640, 16'hC500, 16'h3E00, 16'h4100, 16'hF800, 16'h7800,
                     16'h7BFF, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h8000,
                     16'h3C00, 16'h3800, 16'h3A00};

        reset  = 1'b0;
        R_I    = 1'b0;
        dataIn = '0;
        repeat (3) @(negedge clk);
        check("rst_data16", {16'b0, dataOut16}, 32'd0);
        check("rst_data32", dataOut32, 32'd0);
        check("rst_ro", {31'b0, R_O16}, 32'd0);
        check("rst_err", {31'b0, err16}, 32'd0);
        check("rst_busy", {31'b0, busy16}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        foreach (directed[i]) convert(directed[i]);

        for (int i = 0; i < 150; i++) begin
            h = 16'($urandom);
            if ($urandom_range(0, 3) != 0) h[14:10] = 5'($urandom_range(13, 30));
            convert(h);
        end

        // Extra R_I during SHIFT and during DONE must both be dropped.
        ref_model(16'h5640, 16, v16, e16, lat);
        @(negedge clk);
        dataIn = 16'h5640;
        R_I    = 1'b1;
        @(negedge clk);
        R_I = 1'b0;
        @(negedge clk);
        dataIn = 16'h4500;
        R_I    = 1'b1;
        nro    = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            R_I = 1'b0;
            if (R_O16) begin
                nro++;
                check("ignore_data", {16'b0, dataOut16}, {16'b0, v16[15:0]});
                dataIn = 16'h4500;
                R_I    = 1'b1;
            end
        end
        check("ignore_ro_count", nro, 1);
        check("ignore_idle", {31'b0, busy16}, 32'd0);

        // Asynchronous reset in the middle of a conversion.
        convert(16'h5640);
        @(negedge clk);
        dataIn = 16'h4500;
        R_I    = 1'b1;
        @(negedge clk);
        R_I = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy_before", {31'b0, busy16}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_data16", {16'b0, dataOut16}, 32'd0);
        check("mid_rst_data32", dataOut32, 32'd0);
        check("mid_rst_busy", {31'b0, busy16}, 32'd0);
        check("mid_rst_ro", {31'b0, R_O16}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        nro   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (R_O16 || R_O32) nro++;
        end
        check("mid_rst_no_ro", nro, 0);
        convert(16'h4500);
        convert(16'hC500);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
